// File: rtl/sd_pkg.sv
// Shared definitions for the SD DMA engines (memory reader and writer).
package sd_pkg;

  localparam int SD_DMA_FIFO_AW = 7;
  localparam int SD_DMA_LEN_W   = 16;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} dma_state_e;

  // SD streams bytes MSB-first; memory words are little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/sd_dma_fifo.sv
// Word FIFO for the SD DMA engines: synchronous write, asynchronous read at the read pointer.
// One slot is sacrificed so that full and empty can be told apart from the pointers alone.
module sd_dma_fifo #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic [AW-1:0] o_level,
  output logic          o_empty,
  output logic          o_full
);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW-1:0] w_wptr_inc;
  logic          w_do_push, w_do_pop;

  assign w_wptr_inc = r_wptr + AW'(1);
  assign o_empty    = (r_wptr == r_rptr);
  assign o_full     = (w_wptr_inc == r_rptr);
  assign o_level    = r_wptr - r_rptr;
  assign o_data     = r_mem[r_rptr];
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= w_wptr_inc;
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Producers must hold back on credit; a push into a full FIFO is a producer bug.
  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_push && o_full && !i_flush));

endmodule

// File: rtl/sd_dma_reader.sv
// Memory-to-SD read DMA: fetches words over the memory bus into a FIFO drained by the SD TX path.
// Optional: define SD_DMA_READER_BYTE_SWAP_EN to byte-reverse each word on its way into the FIFO.
module sd_dma_reader
  import sd_pkg::*;
#(
  parameter int FIFO_AW = SD_DMA_FIFO_AW,
  parameter int LEN_W   = SD_DMA_LEN_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [31:0]      i_address,
  input  logic [LEN_W-1:0] i_length,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_request,
  output logic             o_write,
  output logic [31:0]      o_address,
  input  logic             i_busy,
  input  logic             i_ack,
  input  logic [31:0]      i_data,
  input  logic             i_fifo_flush,
  input  logic             i_fifo_pop,
  output logic             o_fifo_empty,
  output logic             o_fifo_full,
  output logic [31:0]      o_fifo_data
);

  localparam logic [FIFO_AW:0] CAPACITY = {1'b0, {FIFO_AW{1'b1}}};

  dma_state_e         r_state, w_state_nxt;
  logic [31:0]        r_address;
  logic [LEN_W-1:0]   r_remaining;
  logic [FIFO_AW-1:0] r_inflight, w_inflight_nxt, w_level;
  logic               r_discard, r_done, w_done_nxt;
  logic               w_accept, w_ack, w_push, w_credit, w_load;
  logic [31:0]        w_push_data;
  logic               w_unused_addr;

  assign w_unused_addr = ^i_address[1:0];

  assign w_accept = o_request && !i_busy;
  // Stray acks with nothing outstanding (e.g. after a reset) are dropped.
  assign w_ack    = i_ack && (r_inflight != '0);
  assign w_push   = w_ack && !r_discard;
  assign w_credit = ({1'b0, w_level} + {1'b0, r_inflight}) < CAPACITY;
  assign w_load   = (r_state == IDLE) && i_start && !i_fifo_flush && (i_length != '0);

`ifdef SD_DMA_READER_BYTE_SWAP_EN
  assign w_push_data = bswap32(i_data);
`else
  assign w_push_data = i_data;
`endif

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_accept && !w_ack)      w_inflight_nxt = r_inflight + FIFO_AW'(1);
    else if (!w_accept && w_ack) w_inflight_nxt = r_inflight - FIFO_AW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (i_fifo_flush) begin
      if (r_state != IDLE) w_state_nxt = (w_inflight_nxt != '0) ? DRAIN : IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_length == '0) w_done_nxt  = 1'b1;
            else                w_state_nxt = FETCH;
          end
        end
        FETCH: if (w_accept && (r_remaining == LEN_W'(1))) w_state_nxt = DRAIN;
        DRAIN: begin
          if (w_inflight_nxt == '0) begin
            w_state_nxt = IDLE;
            w_done_nxt  = !r_discard;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy    = (r_state != IDLE);
    o_request = (r_state == FETCH) && (r_remaining != '0) && w_credit && !i_fifo_flush;
    o_write   = 1'b0;
    o_address = r_address;
    o_done    = r_done;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_address   <= '0;
      r_remaining <= '0;
      r_inflight  <= '0;
      r_discard   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_done     <= w_done_nxt;
      if (w_load) begin
        r_address   <= {i_address[31:2], 2'b00};
        r_remaining <= i_length;
      end else if (w_accept) begin
        r_address   <= r_address + 32'd4;
        r_remaining <= r_remaining - LEN_W'(1);
      end
      // Reads already on the bus at flush time must still be absorbed, but their data dropped.
      if (i_fifo_flush)               r_discard <= (r_state != IDLE) && (w_inflight_nxt != '0);
      else if (w_state_nxt == IDLE)   r_discard <= 1'b0;
    end
  end

  sd_dma_fifo #(
    .AW (FIFO_AW),
    .DW (32)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (i_fifo_flush),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (i_fifo_pop),
    .o_data  (o_fifo_data),
    .o_level (w_level),
    .o_empty (o_fifo_empty),
    .o_full  (o_fifo_full)
  );

endmodule

// File: tb/tb_sd_dma_reader.sv
// Directed bench for sd_dma_reader with a fixed-latency memory responder and optional stall.
module tb_sd_dma_reader;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_address = '0;
  logic [15:0] i_length = '0;
  logic        o_busy, o_done, o_request, o_write;
  logic [31:0] o_address;
  logic        i_busy = 1'b0;
  logic        i_ack = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_fifo_flush = 1'b0;
  logic        i_fifo_pop = 1'b0;
  logic        o_fifo_empty, o_fifo_full;
  logic [31:0] o_fifo_data;

  sd_dma_reader dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_address    (i_address),
    .i_length     (i_length),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_request    (o_request),
    .o_write      (o_write),
    .o_address    (o_address),
    .i_busy       (i_busy),
    .i_ack        (i_ack),
    .i_data       (i_data),
    .i_fifo_flush (i_fifo_flush),
    .i_fifo_pop   (i_fifo_pop),
    .o_fifo_empty (o_fifo_empty),
    .o_fifo_full  (o_fifo_full),
    .o_fifo_data  (o_fifo_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'h1122_3344;
    return {16'hCAFE, a[15:0]};
  endfunction

  function automatic logic [31:0] exp_push(input logic [31:0] d);
`ifdef SD_DMA_READER_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // Memory responder: acks in order, ack_lat cycles after acceptance.
  typedef struct {int due; logic [31:0] data;} rsp_t;
  rsp_t        rq[$];
  logic [31:0] acc_addr[$];
  int          n_acc = 0;
  int          ack_lat = 2;
  int          stall_idx = -1;
  int          stall_len = 0;
  int          stall_cnt = 0;

  always @(negedge clk) begin
    i_ack  = 1'b0;
    i_data = '0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      i_ack  = 1'b1;
      i_data = rq[0].data;
      void'(rq.pop_front());
    end
    i_busy = 1'b0;
    if (o_request && n_acc == stall_idx && stall_cnt < stall_len) begin
      i_busy = 1'b1;
      stall_cnt++;
      chk("stall_addr_hold", o_address, 32'h0000_1004);
    end
    if (o_request && !i_busy) begin
      rq.push_back('{cyc + ack_lat, mem_word(o_address)});
      acc_addr.push_back(o_address);
      n_acc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [15:0] n);
    i_start   = 1'b1;
    i_address = a;
    i_length  = n;
    step();
    i_start = 1'b0;
  endtask

  task automatic run(input int n, output int dones);
    dones = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (o_done) begin
        dones++;
        chk("done_busy_low", 32'(o_busy), 32'd0);
      end
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk(tag, o_fifo_data, exp);
    i_fifo_pop = 1'b1;
    step();
    i_fifo_pop = 1'b0;
  endtask

  task automatic flush_fifo();
    i_fifo_flush = 1'b1;
    step();
    i_fifo_flush = 1'b0;
  endtask

  task automatic clear_bus();
    n_acc = 0;
    acc_addr.delete();
  endtask

  initial begin
    int d, fcyc, low_at, s, vis, dcyc;

    // Reset
    repeat (3) step();
    i_reset = 1'b0;
    chk("rst_request", 32'(o_request), 32'd0);
    chk("rst_write", 32'(o_write), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_address", o_address, 32'd0);
    chk("rst_empty", 32'(o_fifo_empty), 32'd1);
    chk("rst_full", 32'(o_fifo_full), 32'd0);

    // Basic transfer
    clear_bus();
    start_xfer(32'h0000_1000, 16'd4);
    chk("basic_first_req", 32'(o_request), 32'd1);
    chk("basic_busy_rise", 32'(o_busy), 32'd1);
    chk("basic_first_addr", o_address, 32'h0000_1000);
    run(20, d);
    chk("basic_dones", d, 1);
    chk("basic_accepts", n_acc, 4);
    chk("basic_addr0", acc_addr[0], 32'h0000_1000);
    chk("basic_addr1", acc_addr[1], 32'h0000_1004);
    chk("basic_addr2", acc_addr[2], 32'h0000_1008);
    chk("basic_addr3", acc_addr[3], 32'h0000_100C);
    pop_chk("basic_word0", exp_push(32'hCAFE_1000));
    pop_chk("basic_word1", exp_push(32'hCAFE_1004));
    pop_chk("basic_word2", exp_push(32'hCAFE_1008));
    pop_chk("basic_word3", exp_push(32'hCAFE_100C));
    chk("basic_empty", 32'(o_fifo_empty), 32'd1);

    // Stall on the second request
    clear_bus();
    stall_idx = 1;
    stall_len = 5;
    stall_cnt = 0;
    start_xfer(32'h0000_1000, 16'd4);
    run(30, d);
    chk("stall_cycles", stall_cnt, 5);
    chk("stall_accepts", n_acc, 4);
    chk("stall_addr1", acc_addr[1], 32'h0000_1004);
    chk("stall_addr3", acc_addr[3], 32'h0000_100C);
    chk("stall_dones", d, 1);
    stall_idx = -1;
    flush_fifo();
    chk("stall_flushed", 32'(o_fifo_empty), 32'd1);

    // Backpressure
    clear_bus();
    start_xfer(32'h0000_4000, 16'd300);
    run(200, d);
    chk("bp_accepts", n_acc, 127);
    chk("bp_full", 32'(o_fifo_full), 32'd1);
    chk("bp_req_low", 32'(o_request), 32'd0);
    chk("bp_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 10; i++) pop_chk("bp_pop", exp_push(32'hCAFE_4000 + 32'(4 * i)));
    run(20, d);
    chk("bp_accepts_after_pop", n_acc, 137);
    chk("bp_full_again", 32'(o_fifo_full), 32'd1);
    chk("bp_no_done", d, 0);
    pop_chk("bp_word10", exp_push(32'hCAFE_4028));
    flush_fifo();
    step();
    chk("bp_flush_idle", 32'(o_busy), 32'd0);
    chk("bp_flush_empty", 32'(o_fifo_empty), 32'd1);

    // Zero length
    clear_bus();
    start_xfer(32'h0000_6000, 16'd0);
    chk("zero_done", 32'(o_done), 32'd1);
    chk("zero_busy", 32'(o_busy), 32'd0);
    chk("zero_req", 32'(o_request), 32'd0);
    step();
    chk("zero_done_pulse", 32'(o_done), 32'd0);
    chk("zero_accepts", n_acc, 0);

    // Flush with three reads outstanding
    clear_bus();
    ack_lat = 6;
    start_xfer(32'h0000_3000, 16'd8);
    step();
    step();
    step();
    chk("flush_inflight", n_acc, 3);
    fcyc = cyc;
    flush_fifo();
    chk("flush_req_drop", 32'(o_request), 32'd0);
    chk("flush_busy_drain", 32'(o_busy), 32'd1);
    start_xfer(32'h0000_5000, 16'd2);
    low_at = -1;
    d = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_done) d++;
      if (!o_busy && low_at < 0) low_at = cyc;
    end
    chk("flush_busy_fall", low_at, fcyc + 6);
    chk("flush_no_done", d, 0);
    chk("flush_empty", 32'(o_fifo_empty), 32'd1);
    chk("flush_start_ignored", n_acc, 3);
    ack_lat = 2;

    // Byte order, push latency and done timing
    clear_bus();
    s = cyc;
    start_xfer(32'h0000_2000, 16'd1);
    vis  = -1;
    dcyc = -1;
    for (int k = 0; k < 20; k++) begin
      if (!o_fifo_empty && vis < 0) vis = cyc;
      if (o_done && dcyc < 0) dcyc = cyc;
      step();
    end
    chk("swap_visible_cycle", vis, s + 4);
    chk("swap_done_cycle", dcyc, s + 4);
    chk("swap_data", o_fifo_data, exp_push(32'h1122_3344));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
